// File: rtl/inst_mem_loader.sv
// Instruction memory with a program load/run/halt controller.
// Ports: Clk, Reset (sync, active-high); LoadValid/LoadData/LoadLast/LoadReady
//   stream the program in; ProgCtr -> Instruction fetch; Done freezes the PC;
//   Running flags RUN; LoadCount is the loaded word count.
//   Optional macro INST_MEM_CYCLE_COUNT_EN adds CycleCount[15:0].
module inst_mem_loader #(
   parameter int             T       = 10,
   parameter int             IW      = 9,
   parameter logic [IW-1:0]  HALT_OP = 9'h1FF,
   parameter logic [IW-1:0]  NOP_OP  = 9'h000
) (
   input  logic          Clk,
   input  logic          Reset,
   input  logic          LoadValid,
   input  logic [IW-1:0] LoadData,
   input  logic          LoadLast,
   output logic          LoadReady,
   input  logic [T-1:0]  ProgCtr,
   output logic [IW-1:0] Instruction,
   output logic          Done,
   output logic          Running,
`ifdef INST_MEM_CYCLE_COUNT_EN
   output logic [15:0]   CycleCount,
`endif
   output logic [T:0]    LoadCount
);

   typedef enum logic [1:0] {
      LOAD = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } state_t;

   localparam int          DEPTH   = 2**T;
   localparam logic [T-1:0] PTR_MAX = '1;
   localparam logic [T:0]   ONE     = {{T{1'b0}}, 1'b1};

   state_t        state, state_nxt;
   logic [T-1:0]  ptr;
   logic [T:0]    ptr_inc;
   logic          wr_en;
   logic          in_range;
   logic [IW-1:0] fetch;
   logic [IW-1:0] mem [0:DEPTH-1];

   assign ptr_inc  = {1'b0, ptr} + ONE;
   // Addresses at or beyond the loaded length read as a halt.
   assign in_range = {1'b0, ProgCtr} < LoadCount;
   assign fetch    = in_range ? mem[ProgCtr] : HALT_OP;

   always_comb begin
      state_nxt   = state;
      wr_en       = 1'b0;
      LoadReady   = 1'b0;
      Running     = 1'b0;
      Instruction = NOP_OP;
      Done        = 1'b1;
      unique case (state)
         LOAD: begin
            LoadReady = 1'b1;
            wr_en     = LoadValid;
            // A full memory forces RUN regardless of LoadLast.
            if (LoadValid && (LoadLast || ptr == PTR_MAX))
               state_nxt = RUN;
         end
         RUN: begin
            Running     = 1'b1;
            Instruction = fetch;
            // Combinational so the PC stalls on the halt itself.
            Done        = (fetch == HALT_OP);
            if (fetch == HALT_OP)
               state_nxt = HALT;
         end
         HALT: begin
            state_nxt = HALT;
         end
         default: begin
            state_nxt = LOAD;
         end
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state     <= LOAD;
         ptr       <= '0;
         LoadCount <= '0;
      end else begin
         state <= state_nxt;
         if (wr_en) begin
            ptr       <= ptr_inc[T-1:0];
            LoadCount <= ptr_inc;
         end
      end
   end

   // Memory is never cleared; Reset only blocks a same-cycle write.
   always_ff @(posedge Clk) begin
      if (wr_en && !Reset)
         mem[ptr] <= LoadData;
   end

`ifdef INST_MEM_CYCLE_COUNT_EN
   always_ff @(posedge Clk) begin
      if (Reset || state == LOAD)
         CycleCount <= '0;
      else if (state == RUN && CycleCount != 16'hFFFF)
         CycleCount <= CycleCount + 16'd1;
   end
`endif

endmodule

// File: tb/tb_inst_mem_loader.sv
// Scoreboard bench for inst_mem_loader: directed load/run/halt vectors.
module tb_inst_mem_loader;

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic        LoadValid = 1'b0;
   logic [8:0]  LoadData = '0;
   logic        LoadLast = 1'b0;
   logic        LoadReady;
   logic [9:0]  ProgCtr = '0;
   logic [8:0]  Instruction;
   logic        Done;
   logic        Running;
   logic [10:0] LoadCount;
`ifdef INST_MEM_CYCLE_COUNT_EN
   logic [15:0] CycleCount;
`endif

   inst_mem_loader dut (
      .Clk         (Clk),
      .Reset       (Reset),
      .LoadValid   (LoadValid),
      .LoadData    (LoadData),
      .LoadLast    (LoadLast),
      .LoadReady   (LoadReady),
      .ProgCtr     (ProgCtr),
      .Instruction (Instruction),
      .Done        (Done),
      .Running     (Running),
`ifdef INST_MEM_CYCLE_COUNT_EN
      .CycleCount  (CycleCount),
`endif
      .LoadCount   (LoadCount)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      string       name;
      logic [8:0]  ins;
      logic        done;
      logic        run;
      logic        rdy;
      logic [10:0] lc;
      int          cc;
   } exp_t;

   exp_t q[$];
   exp_t me;
   int   n_cmp = 0;
   int   n_err = 0;
   int   cc_exp = -1;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   always @(negedge Clk) begin
      if (q.size() != 0) begin
         me = q.pop_front();
         chk({me.name, ".ins"}, 32'(Instruction), 32'(me.ins));
         chk({me.name, ".done"}, 32'(Done), 32'(me.done));
         chk({me.name, ".run"}, 32'(Running), 32'(me.run));
         chk({me.name, ".rdy"}, 32'(LoadReady), 32'(me.rdy));
         chk({me.name, ".lc"}, 32'(LoadCount), 32'(me.lc));
`ifdef INST_MEM_CYCLE_COUNT_EN
         if (me.cc >= 0)
            chk({me.name, ".cc"}, 32'(CycleCount), 32'(me.cc));
`endif
      end
   end

   task automatic cyc(input string nm, input logic rst, input logic lv,
                      input logic [8:0] ld, input logic ll,
                      input logic [9:0] pc, input logic [8:0] ei,
                      input logic ed, input logic er, input logic ey,
                      input logic [10:0] el);
      exp_t e;
      Reset     = rst;
      LoadValid = lv;
      LoadData  = ld;
      LoadLast  = ll;
      ProgCtr   = pc;
      e = '{nm, ei, ed, er, ey, el, cc_exp};
      q.push_back(e);
      cc_exp = -1;
      @(posedge Clk);
      #1;
   endtask

   task automatic do_reset();
      Reset     = 1'b1;
      LoadValid = 1'b0;
      LoadLast  = 1'b0;
      @(posedge Clk);
      #1;
      Reset = 1'b0;
   endtask

   function automatic logic [8:0] wd(input int i);
      return 9'(i) ^ 9'h0A5;
   endfunction

   initial begin
      // 3-word program ending in halt
      do_reset();
      cyc("t1_rst", 0, 0, 9'h000, 0, 0, 9'h000, 1, 0, 1, 0);
      cyc("t1_w0", 0, 1, 9'h011, 0, 0, 9'h000, 1, 0, 1, 0);
      cyc("t1_w1", 0, 1, 9'h022, 0, 0, 9'h000, 1, 0, 1, 1);
      cyc("t1_w2", 0, 1, 9'h1FF, 1, 0, 9'h000, 1, 0, 1, 2);
      cyc("t1_pc0", 0, 0, 9'h000, 0, 0, 9'h011, 0, 1, 0, 3);
      cyc("t1_pc1", 0, 0, 9'h000, 0, 1, 9'h022, 0, 1, 0, 3);
      cyc("t1_pc2", 0, 0, 9'h000, 0, 2, 9'h1FF, 1, 1, 0, 3);
      cyc("t1_halt", 0, 1, 9'h033, 1, 0, 9'h000, 1, 0, 0, 3);
      cyc("t1_hold", 0, 0, 9'h000, 0, 0, 9'h000, 1, 0, 0, 3);

      // runaway guard
      do_reset();
      cyc("t2_rst", 0, 0, 9'h000, 0, 0, 9'h000, 1, 0, 1, 0);
      cyc("t2_w0", 0, 1, 9'h005, 0, 0, 9'h000, 1, 0, 1, 0);
      cyc("t2_w1", 0, 1, 9'h006, 1, 0, 9'h000, 1, 0, 1, 1);
      cyc("t2_pc0", 0, 0, 9'h000, 0, 0, 9'h005, 0, 1, 0, 2);
      cyc("t2_pc1", 0, 0, 9'h000, 0, 1, 9'h006, 0, 1, 0, 2);
      cyc("t2_pc2", 0, 0, 9'h000, 0, 2, 9'h1FF, 1, 1, 0, 2);
      cyc("t2_halt", 0, 0, 9'h000, 0, 0, 9'h000, 1, 0, 0, 2);

      // gaps in LoadValid; LoadLast without LoadValid is ignored
      do_reset();
      cyc("t3_v0", 0, 1, 9'h0AA, 0, 0, 9'h000, 1, 0, 1, 0);
      cyc("t3_gap0", 0, 0, 9'h0CC, 1, 0, 9'h000, 1, 0, 1, 1);
      cyc("t3_gap1", 0, 0, 9'h0CC, 1, 0, 9'h000, 1, 0, 1, 1);
      cyc("t3_v1", 0, 1, 9'h0BB, 1, 0, 9'h000, 1, 0, 1, 1);
      cyc("t3_pc1", 0, 0, 9'h000, 0, 1, 9'h0BB, 0, 1, 0, 2);
      cyc("t3_pc0", 0, 0, 9'h000, 0, 0, 9'h0AA, 0, 1, 0, 2);

      // reset during RUN, then reload a lone halt
      cyc("t4_rst", 1, 0, 9'h000, 0, 1, 9'h0BB, 0, 1, 0, 2);
      cyc("t4_ld", 0, 1, 9'h1FF, 1, 0, 9'h000, 1, 0, 1, 0);
      cyc("t4_pc0", 0, 0, 9'h000, 0, 0, 9'h1FF, 1, 1, 0, 1);
      cyc("t4_halt", 0, 0, 9'h000, 0, 0, 9'h000, 1, 0, 0, 1);

      // fill memory without LoadLast
      do_reset();
      for (int i = 0; i < 1024; i++)
         cyc("t5_ld", 0, 1, wd(i), 0, 0, 9'h000, 1, 0, 1, 11'(i));
      cyc("t5_pc3ff", 0, 0, 9'h000, 0, 10'h3FF, 9'h15A, 0, 1, 0, 1024);
      cyc("t5_pc0", 0, 0, 9'h000, 0, 0, 9'h0A5, 0, 1, 0, 1024);
      cyc("t5_pc15a", 0, 0, 9'h000, 0, 10'h15A, 9'h1FF, 1, 1, 0, 1024);
      cyc("t5_halt", 0, 0, 9'h000, 0, 0, 9'h000, 1, 0, 0, 1024);

      // 4-instruction program; cycle count checked when present
      do_reset();
      cc_exp = 0;
      cyc("t6_w0", 0, 1, 9'h001, 0, 0, 9'h000, 1, 0, 1, 0);
      cc_exp = 0;
      cyc("t6_w1", 0, 1, 9'h002, 0, 0, 9'h000, 1, 0, 1, 1);
      cc_exp = 0;
      cyc("t6_w2", 0, 1, 9'h003, 0, 0, 9'h000, 1, 0, 1, 2);
      cc_exp = 0;
      cyc("t6_w3", 0, 1, 9'h1FF, 1, 0, 9'h000, 1, 0, 1, 3);
      cc_exp = 0;
      cyc("t6_pc0", 0, 0, 9'h000, 0, 0, 9'h001, 0, 1, 0, 4);
      cc_exp = 1;
      cyc("t6_pc1", 0, 0, 9'h000, 0, 1, 9'h002, 0, 1, 0, 4);
      cc_exp = 2;
      cyc("t6_pc2", 0, 0, 9'h000, 0, 2, 9'h003, 0, 1, 0, 4);
      cc_exp = 3;
      cyc("t6_pc3", 0, 0, 9'h000, 0, 3, 9'h1FF, 1, 1, 0, 4);
      for (int k = 0; k < 11; k++) begin
         cc_exp = 4;
         cyc("t6_halt", 0, 0, 9'h000, 0, 10'(k), 9'h000, 1, 0, 0, 4);
      end

      for (int k = 0; k < 4 && q.size() != 0; k++)
         @(negedge Clk);
      if (q.size() != 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL drain: %0d pending expected 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
